// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1) with a single-entry output buffer, framing/overrun flags
// and a registered CTS answer to the transmitter's RTS.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       RTS,
  output logic       CTS,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] H_LAST = CW'(H);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t        state_r;
  logic [CW-1:0] clk_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          armed_r;

  logic start_det_s;
  logic good_frame_s;
  logic buf_free_s;

  // clk_cnt_r counts cycles since the previous sample point, starting at 1.
  assign start_det_s  = (state_r == IDLE) && armed_r && !serial_in;
  assign good_frame_s = (state_r == STOP) && (clk_cnt_r == C_LAST) && serial_in;
  assign buf_free_s   = !data_valid || rd_en;

  // Frame FSM, output buffer, CTS and status pulses
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_r    <= IDLE;
      clk_cnt_r  <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      armed_r    <= 1'b0;
      CTS        <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      CTS       <= RTS && (state_r == IDLE) && !start_det_s && buf_free_s;

      case (state_r)
        IDLE: begin
          if (serial_in) begin
            armed_r <= 1'b1;
          end
          if (start_det_s) begin
            clk_cnt_r <= CNT_ONE;
            bit_cnt_r <= 3'd0;
            // With H=0 the start recheck coincides with detection itself.
            state_r   <= (H == 0) ? DATA : START;
          end
        end
        START: begin
          if (clk_cnt_r == H_LAST) begin
            clk_cnt_r <= CNT_ONE;
            state_r   <= serial_in ? IDLE : DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt_r == C_LAST) begin
            clk_cnt_r <= CNT_ONE;
            shift_r   <= {serial_in, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (clk_cnt_r == C_LAST) begin
            clk_cnt_r <= '0;
            state_r   <= IDLE;
            if (!serial_in) begin
              frame_err <= 1'b1;
              armed_r   <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (good_frame_s) begin
        if (buf_free_s) begin
          data_out   <= shift_r;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_en) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: one instance at 1 clk/bit, one at 4 clk/bit,
// sharing clock, reset and line stimulus.
module tb_uart_rx_buffered;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       RTS = 1'b0;
  logic       rd_en = 1'b0;
  logic       cts1, dv1, fe1, ov1;
  logic [7:0] do1;
  logic       cts4, dv4, fe4, ov4;
  logic [7:0] do4;

  int tests = 0;
  int fails = 0;
  int tk = 0;
  bit use4 = 1'b0;

  logic       dv_h  [0:63];
  logic       fe_h  [0:63];
  logic       ov_h  [0:63];
  logic       cts_h [0:63];
  logic [7:0] do_h  [0:63];

  uart_rx_buffered #(.CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .rst(rst), .serial_in(serial_in), .RTS(RTS), .CTS(cts1),
    .rd_en(rd_en), .data_out(do1), .data_valid(dv1), .frame_err(fe1), .overrun(ov1)
  );

  uart_rx_buffered #(.CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .rst(rst), .serial_in(serial_in), .RTS(RTS), .CTS(cts4),
    .rd_en(rd_en), .data_out(do4), .data_valid(dv4), .frame_err(fe4), .overrun(ov4)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle and record the selected instance's outputs at index tk.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (tk < 63) tk++;
    dv_h[tk]  = use4 ? dv4  : dv1;
    fe_h[tk]  = use4 ? fe4  : fe1;
    ov_h[tk]  = use4 ? ov4  : ov1;
    cts_h[tk] = use4 ? cts4 : cts1;
    do_h[tk]  = use4 ? do4  : do1;
  endtask

  // Start bit is driven in cycle t0; hist index k then holds the outputs seen in cycle t0+k.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int n, input logic rd_stop);
    tk = 0;
    serial_in = 1'b0;
    repeat (n) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (n) tick();
    end
    serial_in = stop_b;
    rd_en = rd_stop;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    RTS = 1'b1;
    for (int i = 0; i < 2; i++) begin
      serial_in = ~serial_in;
      tick();
      tests++; if (cts1 !== 1'b0) begin fails++; $display("FAIL reset_cts got %b exp 0", cts1); end
      tests++; if (dv1 !== 1'b0) begin fails++; $display("FAIL reset_dv got %b exp 0", dv1); end
      tests++; if (do1 !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", do1); end
      tests++; if (fe1 !== 1'b0 || ov1 !== 1'b0) begin fails++; $display("FAIL reset_pulses got fe=%b ov=%b exp 0", fe1, ov1); end
      tests++; if (cts4 !== 1'b0 || dv4 !== 1'b0) begin fails++; $display("FAIL reset_dut4 got cts=%b dv=%b exp 0", cts4, dv4); end
    end
    rst = 1'b1;
    serial_in = 1'b1;
    tick();
    tests++; if (cts1 !== 1'b1) begin fails++; $display("FAIL cts_after_reset got %b exp 1", cts1); end
  endtask

  task automatic test_basic_rx();
    send_frame(8'h6B, 1'b1, 1, 1'b0);
    tests++; if (cts_h[1] !== 1'b0) begin fails++; $display("FAIL basic_cts_drop got %b exp 0", cts_h[1]); end
    tests++; if (dv_h[9] !== 1'b0) begin fails++; $display("FAIL basic_dv_early got %b exp 0", dv_h[9]); end
    tests++; if (dv_h[10] !== 1'b1) begin fails++; $display("FAIL basic_dv got %b exp 1", dv_h[10]); end
    tests++; if (do_h[10] !== 8'h6B) begin fails++; $display("FAIL basic_data got %h exp 6b", do_h[10]); end
    tests++; if (cts_h[10] !== 1'b0) begin fails++; $display("FAIL basic_cts_full got %b exp 0", cts_h[10]); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (dv1 !== 1'b0) begin fails++; $display("FAIL basic_read_dv got %b exp 0", dv1); end
    tests++; if (do1 !== 8'h6B) begin fails++; $display("FAIL basic_read_hold got %h exp 6b", do1); end
    tests++; if (cts1 !== 1'b1) begin fails++; $display("FAIL basic_cts_back got %b exp 1", cts1); end
  endtask

  task automatic test_overrun();
    send_frame(8'h00, 1'b1, 1, 1'b0);
    tests++; if (dv_h[10] !== 1'b1 || do_h[10] !== 8'h00) begin fails++; $display("FAIL ovr_first got dv=%b data=%h exp 1/00", dv_h[10], do_h[10]); end
    send_frame(8'hFF, 1'b1, 1, 1'b0);
    tests++; if (ov_h[9] !== 1'b0) begin fails++; $display("FAIL ovr_early got %b exp 0", ov_h[9]); end
    tests++; if (ov_h[10] !== 1'b1) begin fails++; $display("FAIL ovr_pulse got %b exp 1", ov_h[10]); end
    tests++; if (do_h[10] !== 8'h00 || dv_h[10] !== 1'b1) begin fails++; $display("FAIL ovr_keep got data=%h dv=%b exp 00/1", do_h[10], dv_h[10]); end
    tick();
    tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL ovr_one_cycle got %b exp 0", ov1); end
    tests++; if (cts1 !== 1'b0) begin fails++; $display("FAIL ovr_cts_full got %b exp 0", cts1); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (dv1 !== 1'b0 || cts1 !== 1'b1) begin fails++; $display("FAIL ovr_read got dv=%b cts=%b exp 0/1", dv1, cts1); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 1, 1'b0);
    send_frame(8'hFF, 1'b1, 1, 1'b1);
    tests++; if (do_h[10] !== 8'hFF) begin fails++; $display("FAIL b2b_data got %h exp ff", do_h[10]); end
    tests++; if (dv_h[10] !== 1'b1) begin fails++; $display("FAIL b2b_dv got %b exp 1", dv_h[10]); end
    tests++; if (ov_h[10] !== 1'b0) begin fails++; $display("FAIL b2b_no_ovr got %b exp 0", ov_h[10]); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_frame_error();
    send_frame(8'hA5, 1'b0, 1, 1'b0);
    tests++; if (fe_h[9] !== 1'b0) begin fails++; $display("FAIL ferr_early got %b exp 0", fe_h[9]); end
    tests++; if (fe_h[10] !== 1'b1) begin fails++; $display("FAIL ferr_pulse got %b exp 1", fe_h[10]); end
    tests++; if (dv_h[10] !== 1'b0) begin fails++; $display("FAIL ferr_dv got %b exp 0", dv_h[10]); end
    repeat (3) tick();
    tests++; if (fe1 !== 1'b0) begin fails++; $display("FAIL ferr_one_cycle got %b exp 0", fe1); end
    tests++; if (cts1 !== 1'b1) begin fails++; $display("FAIL ferr_unarmed got cts=%b exp 1", cts1); end
    serial_in = 1'b1;
    tick();
    send_frame(8'h3C, 1'b1, 1, 1'b0);
    tests++; if (dv_h[10] !== 1'b1 || do_h[10] !== 8'h3C) begin fails++; $display("FAIL ferr_recover got dv=%b data=%h exp 1/3c", dv_h[10], do_h[10]); end
    tests++; if (fe_h[10] !== 1'b0) begin fails++; $display("FAIL ferr_recover_fe got %b exp 0", fe_h[10]); end
  endtask

  task automatic test_oversample();
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    use4 = 1'b1;
    repeat (2) tick();
    tk = 0;
    serial_in = 1'b0;
    repeat (2) tick();
    serial_in = 1'b1;
    repeat (4) tick();
    tests++; if (cts_h[1] !== 1'b0) begin fails++; $display("FAIL glitch_cts_drop got %b exp 0", cts_h[1]); end
    tests++; if (cts_h[3] !== 1'b0) begin fails++; $display("FAIL glitch_cts_start got %b exp 0", cts_h[3]); end
    tests++; if (cts_h[4] !== 1'b1) begin fails++; $display("FAIL glitch_idle got cts=%b exp 1", cts_h[4]); end
    for (int k = 1; k <= 6; k++) begin
      tests++;
      if (dv_h[k] !== 1'b0 || fe_h[k] !== 1'b0 || ov_h[k] !== 1'b0) begin
        fails++; $display("FAIL glitch_quiet[%0d] got dv=%b fe=%b ov=%b exp 0", k, dv_h[k], fe_h[k], ov_h[k]);
      end
    end
    send_frame(8'hC3, 1'b1, 4, 1'b0);
    tests++; if (dv_h[38] !== 1'b0) begin fails++; $display("FAIL os_dv_early got %b exp 0", dv_h[38]); end
    tests++; if (dv_h[39] !== 1'b1) begin fails++; $display("FAIL os_dv got %b exp 1", dv_h[39]); end
    tests++; if (do_h[39] !== 8'hC3) begin fails++; $display("FAIL os_data got %h exp c3", do_h[39]); end
    tests++; if (fe_h[39] !== 1'b0) begin fails++; $display("FAIL os_fe got %b exp 0", fe_h[39]); end
    use4 = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    rst = 1'b0;
    serial_in = 1'b1;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    send_frame(8'h81, 1'b1, 1, 1'b0);
    tests++; if (do_h[10] !== 8'h81) begin fails++; $display("FAIL mfr_pre got %h exp 81", do_h[10]); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    // Frame 8'h0F cut by reset at bit 4; bits 4..7 are low so the tail cannot re-trigger.
    serial_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'b1;
      tick();
    end
    serial_in = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tests++; if (do1 !== 8'h00 || dv1 !== 1'b0) begin fails++; $display("FAIL mfr_reset got data=%h dv=%b exp 00/0", do1, dv1); end
    tests++; if (cts1 !== 1'b0 || fe1 !== 1'b0 || ov1 !== 1'b0) begin fails++; $display("FAIL mfr_reset_flags got cts=%b fe=%b ov=%b exp 0", cts1, fe1, ov1); end
    repeat (3) tick();
    serial_in = 1'b1;
    tick();
    tick();
    tests++; if (dv1 !== 1'b0 || fe1 !== 1'b0) begin fails++; $display("FAIL mfr_tail got dv=%b fe=%b exp 0", dv1, fe1); end
    send_frame(8'h96, 1'b1, 1, 1'b0);
    tests++; if (dv_h[10] !== 1'b1 || do_h[10] !== 8'h96) begin fails++; $display("FAIL mfr_next got dv=%b data=%h exp 1/96", dv_h[10], do_h[10]); end
    tests++; if (fe_h[10] !== 1'b0 || ov_h[10] !== 1'b0) begin fails++; $display("FAIL mfr_next_flags got fe=%b ov=%b exp 0", fe_h[10], ov_h[10]); end
  endtask

  initial begin
    test_reset();
    test_basic_rx();
    test_overrun();
    test_back_to_back();
    test_frame_error();
    test_oversample();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
